// File: rtl/sci_acc_pkg.sv
// rtl/sci_acc_pkg.sv - shared defaults and types for the accelerator dispatch/collect slice
//
// Purpose: default field widths, the dispatch FSM state encoding and the
// core-index type shared by the dispatch arbiter, its order queue and the
// core-side interface.
// Ports: none (package).

package sci_acc_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_MODES_DEF  = 4;
  localparam int unsigned RES_WIDTH_DEF  = 4;
  localparam int unsigned NUM_CORES_DEF  = 4;

  localparam int unsigned CORE_IDX_W = $clog2(NUM_CORES_DEF);
  typedef logic [CORE_IDX_W-1:0] core_idx_t;

  typedef enum logic {
    D_IDLE  = 1'b0,
    D_OFFER = 1'b1
  } disp_state_e;

endpackage

// File: rtl/sci_acc_core_dispatch_arb_if.sv
// rtl/sci_acc_core_dispatch_arb_if.sv - bundle between the dispatch arbiter and the compute cores
//
// Purpose: groups the per-core packet offer, packet fields and result
// handshake signals.
// Modports:
//   master - arbiter side: drives offers, packet fields and result ready
//   slave  - core side: drives ready, pop, final value and done

interface sci_acc_core_dispatch_arb_if
  import sci_acc_pkg::*;
#(
  parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_MODES  = NUM_MODES_DEF,
  parameter int unsigned RES_WIDTH  = RES_WIDTH_DEF
);

  logic [NUM_CORES-1:0]            core_ready;
  logic [NUM_CORES-1:0]            core_op_pkt_available;
  logic [DATA_WIDTH-1:0]           core_data;
  logic [NUM_MODES-1:0]            core_mode;
  logic [RES_WIDTH-1:0]            core_res;
  logic [NUM_CORES-1:0]            core_fifo_pop;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_final_value;
  logic [NUM_CORES-1:0]            core_op_done;
  logic [NUM_CORES-1:0]            core_result_fifo_ready;

  modport master (
    input  core_ready, core_fifo_pop, core_final_value, core_op_done,
    output core_op_pkt_available, core_data, core_mode, core_res,
           core_result_fifo_ready
  );

  modport slave (
    output core_ready, core_fifo_pop, core_final_value, core_op_done,
    input  core_op_pkt_available, core_data, core_mode, core_res,
           core_result_fifo_ready
  );

endinterface

// File: rtl/sci_acc_ord_fifo.sv
// rtl/sci_acc_ord_fifo.sv - order queue of dispatched core indices
//
// Purpose: synchronous FIFO remembering which core received each packet so
// results can be collected in dispatch order.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   push_i/push_data_i enqueue a core index
//   pop_i              dequeue the head entry
//   full_o/empty_o     occupancy flags
//   head_o             core index at the head of the queue

module sci_acc_ord_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is still legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sci_acc_core_dispatch_arb.sv
// rtl/sci_acc_core_dispatch_arb.sv - round-robin packet dispatch and in-order result collection
//
// Purpose: offers each input-FIFO packet to one ready core in round-robin
// order, records the chosen core in an order queue and drains core results
// strictly in dispatch order into the result FIFO.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   in_fifo_data_o/mode_o/res_o    head packet of the input FIFO
//   op_pkt_available, fifo_pop     input FIFO non-empty / pop strobe
//   cores                          core-side bundle (master modport)
//   result_fifo_ready              result FIFO not full
//   result_data, result_wr         result FIFO write data / strobe
//   err_spurious_pop               sticky flag: pop from a non-granted core

module sci_acc_core_dispatch_arb
  import sci_acc_pkg::*;
#(
  parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_MODES  = NUM_MODES_DEF,
  parameter int unsigned RES_WIDTH  = RES_WIDTH_DEF,
  parameter int unsigned ORD_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       in_fifo_data_o,
  input  logic [NUM_MODES-1:0]        in_fifo_mode_o,
  input  logic [RES_WIDTH-1:0]        in_fifo_res_o,
  input  logic                        op_pkt_available,
  output logic                        fifo_pop,
  sci_acc_core_dispatch_arb_if.master cores,
  input  logic                        result_fifo_ready,
  output logic [DATA_WIDTH-1:0]       result_data,
  output logic                        result_wr,
  output logic                        err_spurious_pop
);

  localparam int unsigned IDX_W = $clog2(NUM_CORES);
  typedef logic [IDX_W-1:0] idx_t;

  disp_state_e          state_q;
  idx_t                 grant_q;
  idx_t                 rr_ptr_q;
  logic                 err_q;

  logic [NUM_CORES-1:0] grant_oh;
  logic [NUM_CORES-1:0] head_oh;
  logic [NUM_CORES-1:0] legal_pop;
  logic                 in_offer;
  logic                 dispatch_ok;
  logic                 spurious;
  idx_t                 rr_next;
  logic                 ord_full;
  logic                 ord_empty;
  idx_t                 ord_head;

  // First ready core at or above start, wrapping; rotating a doubled copy of
  // the ready vector turns the wrap into a plain low-to-high scan.
  function automatic idx_t rr_pick(input logic [NUM_CORES-1:0] rdy, input idx_t start);
    logic [2*NUM_CORES-1:0] rot;
    idx_t                   pick;
    logic                   found;
    rot   = {rdy, rdy} >> start;
    pick  = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!found && rot[k]) begin
        pick  = idx_t'((32'(start) + k) % NUM_CORES);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    grant_oh    = '0;
    head_oh     = '0;
    result_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      grant_oh[i] = (idx_t'(i) == grant_q);
      head_oh[i]  = (idx_t'(i) == ord_head);
      if (idx_t'(i) == ord_head) begin
        result_data = cores.core_final_value[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_offer    = (state_q == D_OFFER);
  assign dispatch_ok = op_pkt_available && (|cores.core_ready) && !ord_full;
  assign rr_next     = (grant_q == idx_t'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;

  // Only the granted core may pop, and only while its offer is outstanding.
  assign legal_pop = in_offer ? grant_oh : '0;
  assign fifo_pop  = |(cores.core_fifo_pop & legal_pop);
  assign spurious  = |(cores.core_fifo_pop & ~legal_pop);

  assign cores.core_op_pkt_available = (in_offer && op_pkt_available) ? grant_oh : '0;
  assign cores.core_data             = in_fifo_data_o;
  assign cores.core_mode             = in_fifo_mode_o;
  assign cores.core_res              = in_fifo_res_o;

  // Only the core owning the oldest outstanding packet sees ready, so a core
  // that finishes early simply waits its turn.
  assign cores.core_result_fifo_ready = (result_fifo_ready && !ord_empty) ? head_oh : '0;
  assign result_wr = (|(cores.core_op_done & head_oh)) && result_fifo_ready && !ord_empty;

  assign err_spurious_pop = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= D_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (spurious) begin
        err_q <= 1'b1;
      end
      case (state_q)
        D_IDLE: begin
          if (dispatch_ok) begin
            grant_q <= rr_pick(cores.core_ready, rr_ptr_q);
            state_q <= D_OFFER;
          end
        end
        D_OFFER: begin
          // Grant is held even if the input FIFO empties meanwhile.
          if (fifo_pop) begin
            rr_ptr_q <= rr_next;
            grant_q  <= '0;
            state_q  <= D_IDLE;
          end
        end
        default: state_q <= D_IDLE;
      endcase
    end
  end

  sci_acc_ord_fifo #(
    .DEPTH (ORD_DEPTH),
    .WIDTH (IDX_W)
  ) u_ord_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_pop),
    .push_data_i (grant_q),
    .pop_i       (result_wr),
    .full_o      (ord_full),
    .empty_o     (ord_empty),
    .head_o      (ord_head)
  );

endmodule

// File: tb/tb_sci_acc_core_dispatch_arb.sv
// tb/tb_sci_acc_core_dispatch_arb.sv - scoreboard bench for the dispatch arbiter

module tb_sci_acc_core_dispatch_arb;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int NM = 4;
  localparam int RW = 4;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_data;
  logic [NM-1:0] in_mode;
  logic [RW-1:0] in_res;
  logic          op_avail;
  logic          fifo_pop;
  logic          rfr;
  logic [DW-1:0] result_data;
  logic          result_wr;
  logic          err;

  always #5 clk = ~clk;

  sci_acc_core_dispatch_arb_if #(
    .NUM_CORES(NC), .DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW)
  ) cif ();

  sci_acc_core_dispatch_arb #(
    .NUM_CORES(NC), .DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW), .ORD_DEPTH(OD)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_fifo_data_o    (in_data),
    .in_fifo_mode_o    (in_mode),
    .in_fifo_res_o     (in_res),
    .op_pkt_available  (op_avail),
    .fifo_pop          (fifo_pop),
    .cores             (cif),
    .result_fifo_ready (rfr),
    .result_data       (result_data),
    .result_wr         (result_wr),
    .err_spurious_pop  (err)
  );

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  chk_t          pend_q[$];
  int            exp_grant_q[$];
  logic [DW-1:0] exp_pdata_q[$];
  logic [DW-1:0] exp_res_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_pop    = 0;
  int n_wr     = 0;

  chk_t          mon_c;
  int            mon_g;
  logic [DW-1:0] mon_d;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: drains posted direct checks and scores every pop and result write.
  always @(negedge clk) begin
    while (pend_q.size() != 0) begin
      mon_c = pend_q.pop_front();
      compare(mon_c.name, mon_c.act, mon_c.exp);
    end
    if (reset_n && fifo_pop) begin
      n_pop++;
      if (exp_grant_q.size() == 0) begin
        compare("unexpected_pop", 64'(cif.core_op_pkt_available), 64'(0));
      end else begin
        mon_g = exp_grant_q.pop_front();
        mon_d = exp_pdata_q.pop_front();
        compare("grant", 64'(cif.core_op_pkt_available), 64'(1) << mon_g);
        compare("core_data", 64'(cif.core_data), 64'(mon_d));
      end
    end
    if (reset_n && result_wr) begin
      n_wr++;
      if (exp_res_q.size() == 0) begin
        compare("unexpected_result", 64'(result_data), 64'hDEAD_0000_0000_0000);
      end else begin
        mon_d = exp_res_q.pop_front();
        compare("result_data", 64'(result_data), 64'(mon_d));
      end
    end
  end

  task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    pend_q.push_back(c);
  endtask

  // One cycle; the core model drops done once its result handshake has happened.
  task automatic step();
    logic [NC-1:0] hs;
    @(negedge clk);
    hs = cif.core_result_fifo_ready & cif.core_op_done;
    @(posedge clk);
    #1;
    cif.core_op_done  = cif.core_op_done & ~hs;
    cif.core_fifo_pop = '0;
  endtask

  task automatic dispatch(input logic [DW-1:0] d, input int exp_core);
    bit got;
    got = 1'b0;
    exp_grant_q.push_back(exp_core);
    exp_pdata_q.push_back(d);
    in_data  = d;
    in_mode  = 4'b0010;
    in_res   = d[3:0];
    op_avail = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      if (cif.core_op_pkt_available != '0) begin
        cif.core_fifo_pop = cif.core_op_pkt_available;
        got = 1'b1;
      end
      step();
    end
    op_avail = 1'b0;
    if (!got) post("dispatch_timeout_offer", 64'(cif.core_op_pkt_available), 64'(1) << exp_core);
  endtask

  task automatic set_done(input int core, input logic [DW-1:0] v);
    logic [NC*DW-1:0] lane;
    lane = (NC*DW)'({DW{1'b1}}) << (core * DW);
    cif.core_final_value = (cif.core_final_value & ~lane) | ((NC*DW)'(v) << (core * DW));
    cif.core_op_done     = cif.core_op_done | (NC'(1) << core);
  endtask

  task automatic post_reset_outputs(input string tag);
    post({tag, "_fifo_pop"}, 64'(fifo_pop), 64'(0));
    post({tag, "_offer"}, 64'(cif.core_op_pkt_available), 64'(0));
    post({tag, "_crfr"}, 64'(cif.core_result_fifo_ready), 64'(0));
    post({tag, "_result_wr"}, 64'(result_wr), 64'(0));
    post({tag, "_result_data"}, 64'(result_data), 64'(0));
    post({tag, "_err"}, 64'(err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int w0;
    in_data = '0; in_mode = '0; in_res = '0;
    cif.core_ready       = 4'b1111;
    cif.core_fifo_pop    = '0;
    cif.core_final_value = '0;
    cif.core_op_done     = 4'b1111;
    op_avail = 1'b1;
    rfr      = 1'b1;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    post_reset_outputs("reset");
    op_avail = 1'b0;
    cif.core_op_done = '0;
    reset_n = 1'b1;
    step();

    // All four cores ready: strict rotation 0,1,2,3,0,1,2,3.
    p0 = n_pop;
    for (int k = 1; k <= 8; k++) begin
      dispatch(DW'(k), (k - 1) % 4);
      set_done((k - 1) % 4, DW'(32'h100 + k));
      exp_res_q.push_back(DW'(32'h100 + k));
    end
    repeat (4) step();
    post("t1_pop_count", 64'(n_pop - p0), 64'(8));
    post("t1_err", 64'(err), 64'(0));
    post("t1_drained", 64'(exp_res_q.size()), 64'(0));

    // Only cores 1 and 3 ready.
    cif.core_ready = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      dispatch(DW'(32'h200 + k), (k % 2 == 0) ? 1 : 3);
      set_done((k % 2 == 0) ? 1 : 3, DW'(32'h300 + k));
      exp_res_q.push_back(DW'(32'h300 + k));
    end
    repeat (4) step();

    // Core 2 finishes before core 0; results still leave in dispatch order.
    cif.core_ready = 4'b0101;
    dispatch(32'h21, 0);
    dispatch(32'h22, 2);
    exp_res_q.push_back(32'hB);
    exp_res_q.push_back(32'hA);
    set_done(2, 32'hA);
    for (int i = 0; i < 4; i++) begin
      post("t3_no_wr_before_head", 64'(result_wr), 64'(0));
      step();
    end
    set_done(0, 32'hB);
    repeat (4) step();
    post("t3_drained", 64'(exp_res_q.size()), 64'(0));

    // Result FIFO back-pressure, then a burst of consecutive writes.
    cif.core_ready = 4'b1111;
    rfr = 1'b0;
    dispatch(32'h41, 3);
    dispatch(32'h42, 0);
    dispatch(32'h43, 1);
    set_done(3, 32'h31); exp_res_q.push_back(32'h31);
    set_done(0, 32'h32); exp_res_q.push_back(32'h32);
    set_done(1, 32'h33); exp_res_q.push_back(32'h33);
    for (int i = 0; i < 10; i++) begin
      post("t4_wr_held", 64'(result_wr), 64'(0));
      post("t4_crfr_held", 64'(cif.core_result_fifo_ready), 64'(0));
      step();
    end
    rfr = 1'b1;
    w0 = n_wr;
    for (int i = 1; i <= 3; i++) begin
      step();
      post("t4_burst_writes", 64'(n_wr - w0), 64'(i));
    end

    // Order queue full blocks dispatch until one result drains.
    rfr = 1'b0;
    dispatch(32'h51, 2);
    dispatch(32'h52, 3);
    dispatch(32'h53, 0);
    dispatch(32'h54, 1);
    set_done(2, 32'h61); exp_res_q.push_back(32'h61);
    set_done(3, 32'h62); exp_res_q.push_back(32'h62);
    set_done(0, 32'h63); exp_res_q.push_back(32'h63);
    set_done(1, 32'h64); exp_res_q.push_back(32'h64);
    in_data  = 32'h55;
    op_avail = 1'b1;
    for (int i = 0; i < 5; i++) begin
      post("t5_full_no_offer", 64'(cif.core_op_pkt_available), 64'(0));
      post("t5_full_no_pop", 64'(fifo_pop), 64'(0));
      step();
    end
    rfr = 1'b1;
    step();
    rfr = 1'b0;
    post("t5_idle_in_drain_cycle", 64'(cif.core_op_pkt_available), 64'(0));
    step();
    post("t5_offer_after_drain", 64'(cif.core_op_pkt_available), 64'(4'b0100));
    dispatch(32'h55, 2);
    set_done(2, 32'h65); exp_res_q.push_back(32'h65);
    rfr = 1'b1;
    repeat (8) step();
    post("t5_drained", 64'(exp_res_q.size()), 64'(0));

    // Spurious pop from core 3 while core 1 holds the grant, then reset mid-offer.
    cif.core_ready = 4'b0010;
    in_data  = 32'h66;
    op_avail = 1'b1;
    step();
    post("t6_offer_core1", 64'(cif.core_op_pkt_available), 64'(4'b0010));
    cif.core_fifo_pop = 4'b1000;
    #1;
    post("t6_spurious_no_fifo_pop", 64'(fifo_pop), 64'(0));
    step();
    post("t6_err_set", 64'(err), 64'(1));
    post("t6_grant_held", 64'(cif.core_op_pkt_available), 64'(4'b0010));
    step();
    post("t6_err_sticky", 64'(err), 64'(1));
    reset_n = 1'b0;
    cif.core_final_value = '0;
    cif.core_op_done     = '0;
    #1;
    post_reset_outputs("t6_reset");
    step();
    op_avail = 1'b0;
    reset_n  = 1'b1;
    cif.core_op_done = 4'b1111;
    #1;
    post("t6_queue_empty_no_wr", 64'(result_wr), 64'(0));
    post("t6_queue_empty_crfr", 64'(cif.core_result_fifo_ready), 64'(0));
    post("t6_err_cleared", 64'(err), 64'(0));
    step();
    cif.core_op_done = '0;
    post("end_grant_queue_empty", 64'(exp_grant_q.size()), 64'(0));
    post("end_result_queue_empty", 64'(exp_res_q.size()), 64'(0));
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
